// File: rtl/sequence_generator_if.sv
// Bus between a pattern source and the serial sequence generator:
// load request and pattern fields in one direction, serial bit stream
// and status flags in the other.
interface sequence_generator_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
) ();
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] rep_count;

  logic             data_out;
  logic             data_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, pat_len, rep_count,
    input  data_out, data_valid, frame_start, busy, done
  );

  modport slave (
    input  start, pattern, pat_len, rep_count,
    output data_out, data_valid, frame_start, busy, done
  );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter feeding the sequence detector's data_in.
// Loads a pattern, its length and a repeat count on start, then shifts the
// pattern out MSB-first, one bit per clock, with GAP idle cycles between
// repetitions.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start with a non-zero length
// SEND     | driving pattern[idx] on data_out, one bit per cycle
// GAP_WAIT | idle gap between repetitions; busy stays high
//
// Every output is registered: the comb block computes the next state and
// the output values that belong to that next state, so the first bit is
// on the pins in the cycle right after start is sampled.
module sequence_generator #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  sequence_generator_if.slave  bus
);
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    GAP_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] idx_q, idx_n;
  logic [CNT_W-1:0] rep_q, rep_n;
  logic [GAP_W-1:0] gap_q, gap_n;

  logic             data_out_n;
  logic             data_valid_n;
  logic             frame_start_n;
  logic             busy_n;
  logic             done_n;

  logic [LEN_W-1:0] len_clamped;
  logic [CNT_W-1:0] rep_clamped;
  logic [PAT_W-1:0] pat_shifted;

  // Input clamping: over-long lengths saturate at PAT_W, zero repeats mean one.
  always_comb begin
    len_clamped = (bus.pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.pat_len;
    rep_clamped = (bus.rep_count == '0) ? CNT_W'(1) : bus.rep_count;
  end

  // Next-state, counter and next-output logic.
  always_comb begin
    state_n  = state_q;
    pat_n    = pat_q;
    len_n    = len_q;
    idx_n    = idx_q;
    rep_n    = rep_q;
    gap_n    = gap_q;
    done_n   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.pat_len != '0)) begin
          pat_n   = bus.pattern;
          len_n   = len_clamped;
          idx_n   = len_clamped - LEN_W'(1);
          rep_n   = rep_clamped;
          state_n = SEND;
        end
      end

      SEND: begin
        if (idx_q == '0) begin
          if (rep_q == CNT_W'(1)) begin
            // Last bit of the last repetition: done shows next cycle.
            rep_n   = '0;
            idx_n   = '0;
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            rep_n = rep_q - CNT_W'(1);
            idx_n = len_q - LEN_W'(1);
            if (GAP != 0) begin
              gap_n   = GAP_W'(GAP);
              state_n = GAP_WAIT;
            end
          end
        end else begin
          idx_n = idx_q - LEN_W'(1);
        end
      end

      GAP_WAIT: begin
        if (gap_q == GAP_W'(1)) begin
          gap_n   = '0;
          state_n = SEND;
        end else begin
          gap_n = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs describe the cycle following this edge.
    pat_shifted   = pat_n >> idx_n;
    data_valid_n  = (state_n == SEND);
    data_out_n    = data_valid_n & pat_shifted[0];
    frame_start_n = data_valid_n && (idx_n == (len_n - LEN_W'(1)));
    busy_n        = (state_n != IDLE);
  end

  // State, counters and registered outputs; reset aborts any transfer silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      pat_q           <= '0;
      len_q           <= '0;
      idx_q           <= '0;
      rep_q           <= '0;
      gap_q           <= '0;
      bus.data_out    <= 1'b0;
      bus.data_valid  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      state_q         <= state_n;
      pat_q           <= pat_n;
      len_q           <= len_n;
      idx_q           <= idx_n;
      rep_q           <= rep_n;
      gap_q           <= gap_n;
      bus.data_out    <= data_out_n;
      bus.data_valid  <= data_valid_n;
      bus.frame_start <= frame_start_n;
      bus.busy        <= busy_n;
      bus.done        <= done_n;
    end
  end
endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator. Two instances (GAP=0 and GAP=2)
// see identical stimulus; a reference model expands every accepted start
// into the per-cycle output records it should produce, and a monitor on the
// falling edge pops and compares one record per cycle (all-zero when idle).
module tb_sequence_generator;
  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef logic [4:0] rec_t;   // {data_out, data_valid, frame_start, busy, done}
  typedef rec_t rec_q_t[$];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [LEN_W-1:0] pat_len = '0;
  logic [CNT_W-1:0] rep_count = '0;

  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  bit   mon_en = 1'b0;
  rec_t q0[$];
  rec_t q2[$];

  always #5 clk = ~clk;

  sequence_generator_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus0 ();
  sequence_generator_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus2 ();

  assign bus0.start     = start;
  assign bus0.pattern   = pattern;
  assign bus0.pat_len   = pat_len;
  assign bus0.rep_count = rep_count;
  assign bus2.start     = start;
  assign bus2.pattern   = pattern;
  assign bus2.pat_len   = pat_len;
  assign bus2.rep_count = rep_count;

  sequence_generator #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(0)) u_gap0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  sequence_generator #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(2)) u_gap2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  // Whole transmission as a list of per-cycle output records.
  function automatic rec_q_t expected_frames(input logic [PAT_W-1:0] pat,
                                             input int len_in, input int reps_in,
                                             input int gap);
    rec_q_t           res;
    logic [PAT_W-1:0] sh;
    int               len;
    int               reps;
    len  = (len_in > PAT_W) ? PAT_W : len_in;
    reps = (reps_in == 0) ? 1 : reps_in;
    for (int r = 0; r < reps; r++) begin
      for (int i = len - 1; i >= 0; i--) begin
        sh = pat >> i;
        res.push_back({sh[0], 1'b1, (i == len - 1), 1'b1, 1'b0});
      end
      if (r < reps - 1)
        for (int g = 0; g < gap; g++) res.push_back(5'b00010);
    end
    res.push_back(5'b00001);
    return res;
  endfunction

  // Reference model: a start is taken only when nothing is left to emit.
  always @(posedge clk) begin
    cycle++;
    if (rst) begin
      q0.delete();
      q2.delete();
    end else if (start && (pat_len != '0)) begin
      if (q0.size() == 0) q0 = expected_frames(pattern, int'(pat_len), int'(rep_count), 0);
      if (q2.size() == 0) q2 = expected_frames(pattern, int'(pat_len), int'(rep_count), 2);
    end
  end

  task automatic compare(input string name, input rec_t act, input rec_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got {do,dv,fs,busy,done}=%b expected %b",
               name, cycle, act, exp);
    end
  endtask

  // Monitor: one record per cycle per instance.
  always @(negedge clk) begin
    rec_t e0;
    rec_t e2;
    if (mon_en) begin
      e0 = 5'b0;
      e2 = 5'b0;
      if (q0.size() > 0) e0 = q0.pop_front();
      if (q2.size() > 0) e2 = q2.pop_front();
      compare("gap0", {bus0.data_out, bus0.data_valid, bus0.frame_start, bus0.busy, bus0.done}, e0);
      compare("gap2", {bus2.data_out, bus2.data_valid, bus2.frame_start, bus2.busy, bus2.done}, e2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                          input logic [CNT_W-1:0] r);
    start     = 1'b1;
    pattern   = p;
    pat_len   = l;
    rep_count = r;
    tick();
    start     = 1'b0;
    pattern   = PAT_W'($urandom);
    pat_len   = LEN_W'($urandom);
    rep_count = CNT_W'($urandom);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((q0.size() != 0 || q2.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    tests++;
    if (q0.size() != 0 || q2.size() != 0) begin
      fails++;
      $display("FAIL wait_idle: still %0d/%0d records pending after %0d cycles, required 0",
               q0.size(), q2.size(), max_cycles);
    end
  endtask

  initial begin
    #1;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();

    do_start(8'b1011_0010, LEN_W'(8), CNT_W'(1));
    wait_idle(100);
    repeat (2) tick();

    do_start(8'b0000_0101, LEN_W'(3), CNT_W'(2));
    wait_idle(100);
    repeat (2) tick();

    do_start(8'hFF, LEN_W'(0), CNT_W'(3));
    repeat (20) tick();

    do_start(8'b1011_0010, LEN_W'(8), CNT_W'(1));
    tick();
    do_start(8'h0F, LEN_W'(5), CNT_W'(3));
    wait_idle(100);
    repeat (2) tick();

    do_start(8'h6C, LEN_W'(8), CNT_W'(4));
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    do_start(8'b0000_0010, LEN_W'(2), CNT_W'(1));
    wait_idle(100);
    repeat (2) tick();

    do_start(8'hA5, LEN_W'(12), CNT_W'(0));
    wait_idle(100);
    repeat (2) tick();

    for (int t = 0; t < 40; t++) begin
      do_start(PAT_W'($urandom), LEN_W'($urandom_range(0, 12)), CNT_W'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 30)) tick();
      if ($urandom_range(0, 7) == 0) begin
        rst   = 1'b1;
        start = 1'($urandom_range(0, 1));
        pat_len = LEN_W'($urandom_range(1, 8));
        tick();
        rst   = 1'b0;
        start = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    wait_idle(200);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
